// File: rtl/encoder_pkg.sv
// encoder_pkg: shared widths, FSM state and reset constants for encoder_8_3_queued
package encoder_pkg;
    localparam int N_LINES = 8;
    localparam int CODE_W = 3;
    localparam logic [N_LINES-1:0] PREV_RST = 8'hFF;
    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/prio_pick_8.sv
// prio_pick_8: picks the highest set bit of an 8-bit vector, returning index, one-hot mask and any flag
module prio_pick_8
    import encoder_pkg::*;
(
    input  logic [N_LINES-1:0] req,
    output logic [CODE_W-1:0]  idx,
    output logic [N_LINES-1:0] mask,
    output logic               any
);
    // scan upward so the highest set bit is the last one written
    always_comb begin
        idx = '0;
        mask = '0;
        any = |req;
        for (int k = 0; k < N_LINES; k++)
            if (req[k]) idx = k[CODE_W-1:0];
        mask[idx] = any;
    end
endmodule

// File: rtl/encoder_8_3_queued.sv
// encoder_8_3_queued: registered 8-to-3 priority encoder with pending queue and valid/ready output; GS/EO exist with ENC_CASCADE_EN
module encoder_8_3_queued
    import encoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LINES-1:0] I,
    input  logic               EI,
    output logic [CODE_W-1:0]  Y,
    output logic               V,
    input  logic               R,
    output logic               OVF
`ifdef ENC_CASCADE_EN
    ,
    output logic               GS,
    output logic               EO
`endif
);
    logic [N_LINES-1:0] prev, pending, edges, pick_mask, clr;
    logic [CODE_W-1:0]  pick_idx;
    logic               pick_any, free, load;
    state_t             state, state_nxt;

    assign edges = prev & ~I & {N_LINES{~EI}};
    assign V = state == FULL;

    prio_pick_8 u_pick (
        .req (pending),
        .idx (pick_idx),
        .mask(pick_mask),
        .any (pick_any)
    );

    // slot is free when empty or handing its code over this cycle; refill from registered pending only
    always_comb begin
        free = (state == EMPTY) | R;
        load = free & pick_any;
        state_nxt = free ? (pick_any ? FULL : EMPTY) : state;
        clr = load ? pick_mask : '0;
    end

    // new edges are ORed in after the clear so a same-cycle set wins over the issue
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= PREV_RST;
            pending <= '0;
            state <= EMPTY;
            Y <= '0;
            OVF <= 1'b0;
        end else begin
            prev <= I;
            pending <= (pending & ~clr) | edges;
            state <= state_nxt;
            if (load) Y <= pick_idx;
            OVF <= OVF | (|(edges & pending & ~clr));
        end
    end

`ifdef ENC_CASCADE_EN
    assign GS = ~(V | (|pending));
    assign EO = ~(~EI & ~V & ~(|pending));
`endif
endmodule
